// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream (count, then words) -> word stores, then core release.
// Optional trailing checksum check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        mem_we,
   output logic [2:0]  mem_func3,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StHdr, StLoad, StCsum, StDone, StErr} state_e;
`else
   typedef enum logic [2:0] {StIdle, StHdr, StLoad, StDone, StErr} state_e;
`endif

   state_e      state_q, state_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] count_q, count_d;
   logic [31:0] idx_q, idx_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q, sum_d;
`endif

   logic        accept;
   logic        word_full;
   logic        last_word;
   logic        count_bad;
   logic [31:0] assembled;

   // Earlier bytes sit in shift_q, so the current byte completes the word as its MSB.
   assign accept    = in_valid && in_ready;
   assign word_full = accept && (bcnt_q == 2'd3);
   assign assembled = {in_byte, shift_q};
   assign last_word = (idx_q == count_q - 32'd1);
   assign count_bad = (assembled == 32'd0) || (assembled > 32'(DEPTH_WORDS));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: state_d = StHdr;
         StHdr: begin
            if (word_full) state_d = count_bad ? StErr : StLoad;
         end
         StLoad: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (word_full && last_word) state_d = StCsum;
`else
            if (word_full && last_word) state_d = StDone;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StCsum: begin
            if (word_full) state_d = (assembled == sum_q) ? StDone : StErr;
         end
`endif
         default: state_d = state_q;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_rst  = 1'b1;
      case (state_q)
         StHdr, StLoad: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StCsum: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
`endif
         StDone: begin
            done    = 1'b1;
            cpu_rst = 1'b0;
         end
         StErr:   err = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      count_d = count_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (accept) begin
         shift_d = assembled[31:8];
         bcnt_d  = bcnt_q + 2'd1;
      end
      if ((state_q == StHdr) && word_full) begin
         count_d = assembled;
         idx_d   = 32'd0;
      end
      if ((state_q == StLoad) && word_full) begin
         we_d    = 1'b1;
         addr_d  = BASE_ADDR + (idx_q << 2);
         wdata_d = assembled;
         idx_d   = idx_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_d   = sum_q + assembled;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q  <= 2'd0;
         shift_q <= 24'd0;
         count_q <= 32'd0;
         idx_q   <= 32'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= 32'd0;
`endif
      end else begin
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign mem_we      = we_q;
   assign mem_func3   = 3'b010;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images against a write-list model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_ready;
   logic        mem_we;
   logic [2:0]  mem_func3;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_byte     (in_byte),
      .in_ready    (in_ready),
      .mem_we      (mem_we),
      .mem_func3   (mem_func3),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .cpu_rst     (cpu_rst),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write monitor
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   always @(negedge clk) begin
      if (!rst && mem_we === 1'b1) begin
         wr_addr.push_back(mem_address);
         wr_data.push_back(mem_wdata);
      end
   end

   logic [31:0] img[$];

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns at 1 time unit after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_reset();
      in_valid = 1'b1;
      in_byte  = 8'hA5;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic run_image(input logic [31:0] count, input bit do_reset, input int gmin,
                            input int gmax, input bit bad_csum);
      bit          ok_len;
      bit          exp_ok;
      int          exp_n;
      logic [31:0] sum;
      logic [31:0] w;
      ok_len = (count != 0) && (count <= DEPTH);
      exp_ok = ok_len;
      if (do_reset) apply_reset();
      wr_addr.delete();
      wr_data.delete();
      for (int k = 0; k < 4; k++) begin
         send_byte(count[8*k +: 8]);
         if (k == 3 && !ok_len) begin
            check_eq("len_err", err, 1);
            check_eq("len_cpu_rst", cpu_rst, 1);
            check_eq("len_ready", in_ready, 0);
         end
         idle($urandom_range(gmax, gmin));
      end
      sum = 32'd0;
      if (ok_len) begin
         for (int i = 0; i < int'(count); i++) begin
            w   = img[i];
            sum = sum + w;
            for (int k = 0; k < 4; k++) begin
               send_byte(w[8*k +: 8]);
               check_eq("we_latency", mem_we, (k == 3) ? 32'd1 : 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
               if (k == 3 && i == int'(count) - 1) begin
                  check_eq("done_with_last_we", done, 1);
                  check_eq("cpu_rst_release", cpu_rst, 0);
               end
`endif
               idle($urandom_range(gmax, gmin));
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (bad_csum) sum = sum ^ 32'h1;
         exp_ok = !bad_csum;
         for (int k = 0; k < 4; k++) begin
            send_byte(sum[8*k +: 8]);
            if (k == 3) begin
               check_eq("csum_done", done, exp_ok ? 32'd1 : 32'd0);
               check_eq("csum_err", err, exp_ok ? 32'd0 : 32'd1);
            end
            idle($urandom_range(gmax, gmin));
         end
`endif
      end
      // Offer bytes to a finished loader; none may be taken.
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("final_ready", in_ready, 0);
      check_eq("final_busy", busy, 0);
      check_eq("final_done", done, exp_ok ? 32'd1 : 32'd0);
      check_eq("final_err", err, exp_ok ? 32'd0 : 32'd1);
      check_eq("final_cpu_rst", cpu_rst, exp_ok ? 32'd0 : 32'd1);
      in_valid = 1'b0;
      exp_n = ok_len ? int'(count) : 0;
      check_eq("wr_count", wr_addr.size(), exp_n);
      for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
         check_eq("wr_addr", wr_addr[i], BASE + 32'(4 * i));
         check_eq("wr_data", wr_data[i], img[i]);
      end
      if (bad_csum && ok_len) check_eq("bad_csum_unused", 32'd0, 32'd0 + n_checks - n_checks);
   endtask

   initial begin
      // Reset behaviour with in_valid held high
      rst      = 1'b1;
      in_valid = 1'b1;
      in_byte  = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", in_ready, 0);
      check_eq("rst_cpu_rst", cpu_rst, 1);
      check_eq("rst_we", mem_we, 0);
      check_eq("rst_func3", mem_func3, 3'b010);
      check_eq("rst_addr", mem_address, 0);
      check_eq("rst_wdata", mem_wdata, 0);
      check_eq("rst_flags", {busy, done, err}, 3'b000);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("ready_cycle1", in_ready, 0);
      @(negedge clk);
      check_eq("ready_cycle2", in_ready, 1);

      // Directed two-word image, back-to-back then with 3-cycle stalls
      img = '{32'h0010_0513, 32'h0020_0593};
      run_image(32'd2, 1'b1, 0, 0, 1'b0);
      run_image(32'd2, 1'b1, 3, 3, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      run_image(32'd2, 1'b1, 0, 0, 1'b1);
`endif

      // Length errors and maximum length
      img.delete();
      run_image(32'd0, 1'b1, 0, 0, 1'b0);
      run_image(32'(DEPTH + 1), 1'b1, 0, 1, 1'b0);
      for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
      run_image(32'(DEPTH), 1'b1, 0, 0, 1'b0);

      // Reset after 6 payload bytes, then a fresh image without another reset pulse
      apply_reset();
      for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'd3 : 8'd0);
      for (int k = 0; k < 6; k++) send_byte(8'($urandom));
      rst = 1'b1;
      #1;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_cpu_rst", cpu_rst, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      img.delete();
      for (int i = 0; i < 3; i++) img.push_back($urandom);
      run_image(32'd3, 1'b0, 0, 0, 1'b0);

      // Randomized images with random stalls
      for (int t = 0; t < 6; t++) begin
         int unsigned n;
         n = $urandom_range(DEPTH, 1);
         img.delete();
         for (int i = 0; i < int'(n); i++) img.push_back($urandom);
         run_image(32'(n), 1'b1, 0, 2, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Receives a little-endian byte stream over a valid/ready handshake: a 32-bit word count, then the program words. Writes each assembled word into the instruction RAM's write port as a word store (func3 = 3'b010). Holds the core in reset until the image is fully written, then releases it; the core then reads the same RAM as its instruction fetch path.

## Interface
Parameters:
- DEPTH_WORDS, 1024: instruction RAM capacity in 32-bit words; maximum legal word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_byte holds a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a transfer occurs on a cycle with in_valid && in_ready.
- mem_we  output  1  instruction RAM write strobe, one-cycle pulse per word.
- mem_func3  output  3  access size, constant 3'b010.
- mem_address  output  32  byte address of the write.
- mem_wdata  output  32  write data.
- cpu_rst  output  1  core reset; high until load completes successfully.
- busy  output  1  high in HDR, LOAD and CSUM.
- done  output  1  load completed successfully (sticky).
- err  output  1  load failed (sticky).

## Operation
- States: IDLE, HDR, LOAD, CSUM (only with macro), DONE, ERR.
- IDLE: entered on reset; unconditionally moves to HDR on the next cycle.
- HDR: accepts 4 bytes, LSB first, into the 32-bit count N.
  - After the 4th byte: N == 0 or N > DEPTH_WORDS -> ERR.
  - Otherwise -> LOAD with word index 0 and byte index 0.
- LOAD: accepts bytes LSB first into a shift register.
  - On the 4th byte of a word, latch the word into mem_wdata and mem_address = BASE_ADDR + 4*index.
  - mem_we pulses high on the following cycle.
  - Increment the index.
  - After word N-1's 4th byte -> DONE, or -> CSUM if the macro is enabled.
- DONE: in_ready = 0, done = 1, cpu_rst = 0. Sticky until rst.
- ERR: in_ready = 0, err = 1, cpu_rst = 1, no further writes. Sticky until rst.
- in_ready is combinational from state: 1 in HDR, LOAD and CSUM; 0 otherwise.
- Index counter is 32 bits wide. Address arithmetic is modulo 2^32. The count check guarantees no overflow past DEPTH_WORDS.
- in_valid without in_ready: ignored; the byte is not consumed.
- Stream stall (in_valid low) mid-word: the partial word is held indefinitely; there is no timeout.
- Reset mid-load: all state is discarded and the loader restarts at IDLE. RAM contents already written are left as they are.

## Timing
- Reset values:
  - in_ready = 0, mem_we = 0, mem_func3 = 3'b010, mem_address = 0, mem_wdata = 0.
  - cpu_rst = 1, busy = 0, done = 0, err = 0.
- in_ready rises the 2nd cycle after rst deasserts (IDLE -> HDR).
- Byte throughput: one byte per cycle, with no bubbles.
- Write latency: mem_we is asserted exactly 1 cycle after the accepting edge of a word's 4th byte.
  - The next byte may be accepted in that same cycle.
  - mem_address and mem_wdata stay stable until the next word's latch.
- Completion:
  - Without macro: state is DONE, done = 1 and cpu_rst = 0 in the same cycle as the final mem_we pulse.
  - With macro: done = 1 and cpu_rst = 0 appear in the cycle after CSUM accepts its 4th byte.
- err is asserted the cycle after the failing byte is accepted.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the payload, CSUM accepts 4 more bytes, LSB first, as checksum C.
  - The loader keeps a running 32-bit sum S of all payload words, modulo 2^32.
  - C == S -> DONE. C != S -> ERR, and cpu_rst stays high.
- Not defined: no CSUM state and no sum register; LOAD goes directly to DONE.

## Test plan
- Reset: hold rst with in_valid = 1 -> in_ready = 0, cpu_rst = 1, mem_we = 0. in_ready = 1 two cycles after release.
- Normal load, BASE_ADDR = 0, stream 02 00 00 00, 13 05 10 00, 93 05 20 00 back-to-back:
  - mem_we pulses twice: 0x0 <- 0x00100513, then 0x4 <- 0x00200593.
  - done = 1, cpu_rst = 0; in_ready = 0 thereafter.
- Stalls: same stream with in_valid low for 3 cycles between every byte -> identical writes; exactly 2 mem_we pulses; no write before each word's 4th byte.
- Length errors:
  - Count 00 00 00 00 -> err = 1, no mem_we, cpu_rst stays 1.
  - Count DEPTH_WORDS+1 -> same response.
  - Count DEPTH_WORDS -> accepted; last write at BASE_ADDR + 4*(DEPTH_WORDS-1).
- Reset mid-load: assert rst after 6 payload bytes -> busy = 0. A full new image then loads from index 0 and ends with done = 1.
- With IMEM_LOADER_CHECKSUM_EN, the above 2-word image:
  - Trailer A6 0A 30 00 (0x00300AA6) -> done = 1.
  - Trailer A7 0A 30 00 -> err = 1, cpu_rst = 1.
